// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length-prefixed image, writes 32-bit words
// into the core's RAM, verifies an 8-bit checksum and then releases the core reset.
module prog_loader #(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [31:0] MAX_N = 32'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_SUM,
      S_DONE,
      S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic [CNT_W-1:0]  word_idx_q, word_idx_d;
   logic [CNT_W-1:0]  n_words_q, n_words_d;
   logic [7:0]        sum_q, sum_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              in_ready_q, in_ready_d;
   logic              core_rst_q, core_rst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              accept;
   logic [31:0]       word;

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      word_idx_d  = word_idx_q;
      n_words_d   = n_words_q;
      sum_d       = sum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      accept = in_valid && in_ready_q;
      word   = {in_data, asm_q};

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         asm_d      = {in_data, asm_q[23:8]};
         case (state_q)
            S_HDR: begin
               if (byte_cnt_q == 2'd3) begin
                  n_words_d  = word[CNT_W-1:0];
                  word_idx_d = '0;
                  if (word == 32'd0) begin
                     state_d = S_SUM;
                  end else if (word > MAX_N) begin
                     state_d = S_ERR;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               sum_d = sum_q + in_data;
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = word_idx_q[ADDR_W-1:0];
                  mem_wdata_d = word;
                  word_idx_d  = word_idx_q + CNT_W'(1);
                  if (word_idx_d == n_words_q) begin
                     state_d = S_SUM;
                  end
               end
            end
            S_SUM: begin
               state_d = (in_data == sum_q) ? S_DONE : S_ERR;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_SUM);
      core_rst_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HDR;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         word_idx_q  <= '0;
         n_words_q   <= '0;
         sum_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         in_ready_q  <= 1'b1;
         core_rst_q  <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         word_idx_q  <= word_idx_d;
         n_words_q   <= n_words_d;
         sum_q       <= sum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         core_rst_q  <= core_rst_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign core_rst  = core_rst_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11; word-address width of the target RAM (2048 words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_data  input  8  upstream byte.
REQ-006 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-007 SHALL have port mem_we  output  1  RAM word write strobe.
REQ-008 SHALL have port mem_addr  output  ADDR_W  RAM word address.
REQ-009 SHALL have port mem_wdata  output  32  RAM write data.
REQ-010 SHALL have port core_rst  output  1  reset to the rv32 core; high holds the core in reset.
REQ-011 SHALL have port done  output  1  image loaded and verified.
REQ-012 SHALL have port err  output  1  load failed.

Function
REQ-013 SHALL accept a byte only on a rising edge with in_valid && in_ready; at most one byte per cycle; back-to-back bytes SHALL be accepted with no bubbles.
REQ-014 SHALL implement states HDR, DATA, SUM, DONE, ERR; in_ready = 1 in HDR/DATA/SUM, 0 in DONE/ERR (decoded from state only, not from in_valid).
REQ-015 Stream format SHALL be: 4-byte word count N (little-endian), then N 32-bit words (each little-endian, LSB first), then one checksum byte.
REQ-016 HDR: after the 4th accepted byte, N==0 -> SUM; N > 2**ADDR_W -> ERR; otherwise -> DATA.
REQ-017 DATA: bytes SHALL be assembled LSB first; on the edge accepting the 4th byte of a word, mem_we SHALL go 1 for exactly one cycle with mem_addr = word index (0 for the first word, incrementing by 1) and mem_wdata = the assembled word.
REQ-018 Write latency SHALL be 1 cycle: mem_we is high in the cycle after the 4th byte is accepted; writes SHALL NOT stall byte acceptance.
REQ-019 After word N-1 is accepted, the state SHALL go to SUM; a count of exactly 2**ADDR_W SHALL write addresses 0..2**ADDR_W-1 with no wrap.
REQ-020 The checksum SHALL be the 8-bit modulo-256 sum of all payload bytes; header bytes are excluded.
REQ-021 SUM: on acceptance, match -> DONE, mismatch -> ERR.
REQ-022 DONE: from the cycle after entry, core_rst = 0 and done = 1, held until rst.
REQ-023 ERR: err = 1 and core_rst = 1, held until rst.
REQ-024 In DONE/ERR, in_valid/in_data SHALL be ignored and no mem_we SHALL occur.
REQ-025 mem_addr/mem_wdata SHALL hold their last values when mem_we = 0.

Reset
REQ-026 While rst = 1 at an edge: state = HDR, all counters, the checksum and the assembly register = 0; mem_we = 0, mem_addr = 0, mem_wdata = 0, core_rst = 1, done = 0, err = 0; in_ready = 1 after release.
REQ-027 rst mid-stream SHALL discard partial header/word/checksum with no write in or after the reset cycle; the next stream SHALL start from HDR.

Verification
REQ-028 Send 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | B6 -> writes addr0 = 0x00000013, addr1 = 0x00100093, each 1 cycle after its 4th byte; then done = 1, core_rst = 0, in_ready = 0.
REQ-029 Send 00 00 00 00 | 00 -> no mem_we; done = 1, core_rst = 0.
REQ-030 Send the REQ-028 stream with checksum B7 -> both words written; err = 1, core_rst = 1, done = 0.
REQ-031 With ADDR_W = 11, send header 01 08 00 00 (N = 2049) -> err = 1 the cycle after the 4th byte; no mem_we; further bytes ignored.
REQ-032 Send the REQ-028 stream with random in_valid gaps -> identical writes and final state to REQ-028.
REQ-033 Assert rst for 1 cycle after header + 2 data bytes, then send the REQ-028 stream -> no write before the rerun; rerun ends exactly as in REQ-028.
